sym_err_counter: RTL

- Symbol-error counter for the inphase 4-ASK path. Sits downstream of the 4-ASK slicer and beside the MER error accumulators.
- Compares sliced symbols against the transmitted inphase bits of the LFSR symbol stream.
- Finds the channel/pipeline delay automatically, so the delay no longer has to be hand-tuned.
- Reports error and symbol counts per LFSR period, plus a live per-symbol error flag for the LEDs.

---
 rtl/sym_err_counter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sym_err_counter.sv
// Inphase 4-ASK symbol-error counter: finds the reference delay by sweeping
// candidates, then counts errors and symbols per LFSR period while locked.
module sym_err_counter #(
    parameter int unsigned SYM_W        = 2,
    parameter int unsigned MAX_DELAY    = 15,
    parameter int unsigned DLY_W        = 4,
    parameter int unsigned LOCK_WIN     = 64,
    parameter int unsigned LOCK_ERR_MAX = 2,
    parameter int unsigned LOSS_ERR_MAX = 16,
    parameter int unsigned CNT_W        = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             hold,
    input  logic [SYM_W-1:0] sym_ref,
    input  logic [SYM_W-1:0] sym_rx,
    output logic [DLY_W-1:0] delay_out,
    output logic             locked,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sym_count,
    output logic             meas_valid
);

    localparam int unsigned     WIN_W     = $clog2(LOCK_WIN + 1);
    localparam logic [0:0]      ST_SEARCH = 1'b0;
    localparam logic [0:0]      ST_LOCKED = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [SYM_W-1:0] ref_dl_q [MAX_DELAY+1];
    logic [SYM_W-1:0] ref_dl_d [MAX_DELAY+1];
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0] win_err_q, win_err_d;
    logic [CNT_W-1:0] acc_err_q, acc_err_d;
    logic [CNT_W-1:0] acc_sym_q, acc_sym_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] sym_count_q, sym_count_d;
    logic             err_flag_q, err_flag_d;
    logic             meas_valid_q, meas_valid_d;

    logic             mismatch_c;
    logic [DLY_W-1:0] next_dly_c;
    logic [WIN_W-1:0] win_cnt_inc_c;
    logic [WIN_W-1:0] win_err_inc_c;
    logic             win_done_c;
    logic [CNT_W-1:0] acc_err_inc_c;
    logic [CNT_W-1:0] acc_sym_inc_c;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a,
                                                 input logic inc);
        sat_inc = (inc && (a != CNT_MAX)) ? a + CNT_W'(1) : a;
    endfunction

    // Compare against the pre-shift delay line, so index 0 is the previous symbol.
    always_comb begin
        mismatch_c    = (sym_rx != ref_dl_q[dly_q]);
        next_dly_c    = (dly_q == DLY_W'(MAX_DELAY)) ? '0 : dly_q + DLY_W'(1);
        win_cnt_inc_c = win_cnt_q + WIN_W'(1);
        win_err_inc_c = win_err_q + WIN_W'(mismatch_c);
        win_done_c    = (win_cnt_inc_c == WIN_W'(LOCK_WIN));
        acc_err_inc_c = sat_inc(acc_err_q, mismatch_c);
        acc_sym_inc_c = sat_inc(acc_sym_q, 1'b1);
    end

    always_comb begin
        state_d      = state_q;
        dly_d        = dly_q;
        ref_dl_d     = ref_dl_q;
        win_cnt_d    = win_cnt_q;
        win_err_d    = win_err_q;
        acc_err_d    = acc_err_q;
        acc_sym_d    = acc_sym_q;
        err_count_d  = err_count_q;
        sym_count_d  = sym_count_q;
        err_flag_d   = err_flag_q;
        meas_valid_d = 1'b0;

        if (clk_en) begin
            ref_dl_d[0] = sym_ref;
            for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
                ref_dl_d[k] = ref_dl_q[k-1];
            end
            err_flag_d = mismatch_c;
            win_cnt_d  = win_cnt_inc_c;
            win_err_d  = win_err_inc_c;

            case (state_q)
                ST_SEARCH: begin
                    // Hold is ignored here, including on the locking symbol.
                    if (win_done_c) begin
                        if (win_err_inc_c <= WIN_W'(LOCK_ERR_MAX)) begin
                            state_d = ST_LOCKED;
                        end else begin
                            dly_d = next_dly_c;
                        end
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end
                end
                default: begin
                    if (win_err_inc_c == WIN_W'(LOSS_ERR_MAX)) begin
                        // Loss of lock beats a coincident hold; partial period is dropped.
                        state_d   = ST_SEARCH;
                        dly_d     = next_dly_c;
                        win_cnt_d = '0;
                        win_err_d = '0;
                        acc_err_d = '0;
                        acc_sym_d = '0;
                    end else begin
                        if (hold) begin
                            err_count_d  = acc_err_inc_c;
                            sym_count_d  = acc_sym_inc_c;
                            acc_err_d    = '0;
                            acc_sym_d    = '0;
                            meas_valid_d = 1'b1;
                        end else begin
                            acc_err_d = acc_err_inc_c;
                            acc_sym_d = acc_sym_inc_c;
                        end
                        if (win_done_c) begin
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_SEARCH;
            dly_q        <= '0;
            ref_dl_q     <= '{default: '0};
            win_cnt_q    <= '0;
            win_err_q    <= '0;
            acc_err_q    <= '0;
            acc_sym_q    <= '0;
            err_count_q  <= '0;
            sym_count_q  <= '0;
            err_flag_q   <= 1'b0;
            meas_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            ref_dl_q     <= ref_dl_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
            acc_err_q    <= acc_err_d;
            acc_sym_q    <= acc_sym_d;
            err_count_q  <= err_count_d;
            sym_count_q  <= sym_count_d;
            err_flag_q   <= err_flag_d;
            meas_valid_q <= meas_valid_d;
        end
    end

    assign delay_out  = dly_q;
    assign locked     = (state_q == ST_LOCKED);
    assign err_flag   = err_flag_q;
    assign err_count  = err_count_q;
    assign sym_count  = sym_count_q;
    assign meas_valid = meas_valid_q;

endmodule
